serdes_tx_frame: RTL and testbench

Parametrised framed serial transmitter, the next generation of the 8-bit SERDES TX. It accepts a parallel word on a level-sensitive send/ready handshake and holds one further word in a holding register, so back-to-back frames go out without gaps. Each frame is start bit, DATA_W data bits, optional parity, then 1 or 2 stop bits, each bit lasting CLKS_PER_BIT clocks. It feeds Sout to the RX side of the link and flags overrun on err.

---
 rtl/serdes_pkg.sv | 35 +++
 rtl/serdes_baud_tick.sv | 35 +++
 rtl/serdes_tx_frame.sv | 184 ++++++++++++++++++
 tb/tb_serdes_tx_frame.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and elaboration helpers for the SERDES TX/RX generation.
//   tx_state_t  : transmitter frame state
//   frame_bits  : serial bits per frame (start + data + parity + stop)
//   clog2       : ceiling log2, used for counter widths on both link sides
//   cnt_width   : clog2 clamped to at least one bit
package serdes_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   function automatic int unsigned frame_bits(input int unsigned data_w,
                                              input int unsigned parity_en,
                                              input int unsigned stop_bits);
      return 1 + data_w + parity_en + stop_bits;
   endfunction

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < value; p = p << 1) begin
         r++;
      end
      return r;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

endpackage

// File: rtl/serdes_baud_tick.sv
// Bit-period timer. Free-running 0..CLKS_PER_BIT-1 counter, held at zero while
// run is low, with a tick on the terminal count.
//   CLOCK_50 : clock, rising edge
//   resetN   : synchronous active-low reset
//   run      : enable; low clears the counter
//   tick     : high in the last clock of each bit period
module serdes_baud_tick
   import serdes_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic CLOCK_50,
   input  logic resetN,
   input  logic run,
   output logic tick
);

   localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLOCK_50) begin
      if (!resetN || !run) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/serdes_tx_frame.sv
// Framed serial transmitter with a one-word holding register.
// Frame: start(0), DATA_W data bits, optional parity, STOP_BITS stop bits(1),
// each bit CLKS_PER_BIT clocks long.
//   CLOCK_50 : clock, rising edge
//   resetN   : synchronous active-low reset
//   Pin      : parallel word, sampled when send && ready
//   send     : level request, one word accepted per cycle with send && ready
//   ready    : holding register empty (combinational)
//   busy     : frame in progress or word queued (registered)
//   Sout     : serial line, idles high (registered)
//   done     : high in the last clock of each frame's final stop bit
//   err      : sticky overrun, set on send while not ready
module serdes_tx_frame
   import serdes_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned LSB_FIRST    = 1
) (
   input  logic              CLOCK_50,
   input  logic              resetN,
   input  logic [DATA_W-1:0] Pin,
   input  logic              send,
   output logic              ready,
   output logic              busy,
   output logic              Sout,
   output logic              done,
   output logic              err
);

   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("serdes_tx_frame: STOP_BITS must be 1 or 2");
   end

   localparam int unsigned IDX_W = cnt_width(DATA_W);

   tx_state_t         state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] hold_data_q;
   logic              par_q;
   logic              hold_par_q;
   logic              hold_valid_q;
   logic [IDX_W-1:0]  bit_idx_q;

   logic              tick;
   logic              accept;
   logic              last_data;
   logic              last_stop;
   logic              frame_end;
   logic [DATA_W-1:0] pin_ordered;
   logic [DATA_W-1:0] shifted;
   logic              pin_par;

   serdes_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .CLOCK_50(CLOCK_50),
      .resetN  (resetN),
      .run     (state_q != IDLE),
      .tick    (tick)
   );

   // Words are stored in transmit order so the shifter always emits bit 0.
   always_comb begin
      pin_ordered = Pin;
      if (LSB_FIRST == 0) begin
         for (int i = 0; i < int'(DATA_W); i++) begin
            pin_ordered[i] = Pin[DATA_W-1-i];
         end
      end
   end

   assign pin_par   = (^Pin) ^ (PARITY_ODD != 0);
   assign shifted   = shreg_q >> 1;
   assign ready     = !hold_valid_q;
   assign accept    = send && !hold_valid_q;
   assign last_data = (bit_idx_q == IDX_W'(DATA_W - 1));
   assign last_stop = (bit_idx_q == IDX_W'(STOP_BITS - 1));
   assign frame_end = (state_q == STOP) && tick && last_stop;
   assign done      = frame_end;

   always_ff @(posedge CLOCK_50) begin
      if (!resetN) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         hold_data_q  <= '0;
         par_q        <= 1'b0;
         hold_par_q   <= 1'b0;
         hold_valid_q <= 1'b0;
         bit_idx_q    <= '0;
         Sout         <= 1'b1;
         busy         <= 1'b0;
         err          <= 1'b0;
      end else begin
         if (send && hold_valid_q) begin
            err <= 1'b1;
         end

         // A word arriving exactly at a frame boundary with hold empty goes
         // straight to the shifter below instead of the holding register.
         if (accept && (state_q != IDLE) && !frame_end) begin
            hold_data_q  <= pin_ordered;
            hold_par_q   <= pin_par;
            hold_valid_q <= 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  shreg_q <= pin_ordered;
                  par_q   <= pin_par;
                  state_q <= START;
                  Sout    <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  state_q   <= DATA;
                  bit_idx_q <= '0;
                  Sout      <= shreg_q[0];
               end
            end
            DATA: begin
               if (tick) begin
                  if (last_data) begin
                     bit_idx_q <= '0;
                     if (PARITY_EN != 0) begin
                        state_q <= PARITY;
                        Sout    <= par_q;
                     end else begin
                        state_q <= STOP;
                        Sout    <= 1'b1;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + IDX_W'(1);
                     shreg_q   <= shifted;
                     Sout      <= shifted[0];
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  state_q <= STOP;
                  Sout    <= 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  if (last_stop) begin
                     bit_idx_q <= '0;
                     if (hold_valid_q) begin
                        shreg_q      <= hold_data_q;
                        par_q        <= hold_par_q;
                        hold_valid_q <= 1'b0;
                        state_q      <= START;
                        Sout         <= 1'b0;
                     end else if (accept) begin
                        shreg_q <= pin_ordered;
                        par_q   <= pin_par;
                        state_q <= START;
                        Sout    <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                        Sout    <= 1'b1;
                        busy    <= 1'b0;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               Sout    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serdes_tx_frame.sv
// Bench for serdes_tx_frame: default configuration (dut0) plus a 5-bit,
// MSB-first, odd-parity, two-stop-bit configuration (dut1).
// The model keeps, per DUT, a queue of expected per-cycle line values
// {done, Sout}; each accepted word appends its whole frame.
module tb_serdes_tx_frame;
   import serdes_pkg::*;

   localparam int DW0  = 8;
   localparam int CPB0 = 4;
   localparam int NB0  = int'(frame_bits(8, 1, 1));
   localparam int F0   = NB0 * CPB0;
   localparam int DW1  = 5;
   localparam int CPB1 = 1;
   localparam int NB1  = int'(frame_bits(5, 1, 2));
   localparam int F1   = NB1 * CPB1;

   logic         clk;
   logic         resetN;
   logic         send0, send1;
   logic [7:0]   pin0;
   logic [4:0]   pin1;
   logic         ready0, busy0, sout0, done0, err0;
   logic         ready1, busy1, sout1, done1, err1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef bit [1:0] ent_t;  // {done, sout}
   ent_t q0[$];
   ent_t q1[$];
   bit   err0_m, err1_m, mvalid;

   logic s0_tr[0:199], d0_tr[0:199], b0_tr[0:199], r0_tr[0:199], e0_tr[0:199];
   logic s1_tr[0:199], d1_tr[0:199], b1_tr[0:199];

   serdes_tx_frame u_dut0 (
      .CLOCK_50(clk), .resetN(resetN), .Pin(pin0), .send(send0),
      .ready(ready0), .busy(busy0), .Sout(sout0), .done(done0), .err(err0)
   );

   serdes_tx_frame #(
      .DATA_W(5), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2),
      .LSB_FIRST(0)
   ) u_dut1 (
      .CLOCK_50(clk), .resetN(resetN), .Pin(pin1), .send(send1),
      .ready(ready1), .busy(busy1), .Sout(sout1), .done(done1), .err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Line value at frame position p (0 = start bit).
   function automatic bit frame_bit(input logic [31:0] w, input int p, input int dw,
                                    input bit pen, input bit podd, input bit lsb);
      bit par;
      par = podd;
      for (int i = 0; i < dw; i++) par ^= w[i];
      if (p == 0) return 1'b0;
      if (p <= dw) return lsb ? w[p-1] : w[dw-p];
      if (pen && p == dw + 1) return par;
      return 1'b1;
   endfunction

   task automatic push_frame(input int which, input logic [31:0] w);
      if (which == 0) begin
         for (int p = 0; p < NB0; p++)
            for (int c = 0; c < CPB0; c++)
               q0.push_back({(p == NB0 - 1) && (c == CPB0 - 1), frame_bit(w, p, DW0, 1, 0, 1)});
      end else begin
         for (int p = 0; p < NB1; p++)
            for (int c = 0; c < CPB1; c++)
               q1.push_back({(p == NB1 - 1) && (c == CPB1 - 1), frame_bit(w, p, DW1, 1, 1, 0)});
      end
   endtask

   // Model step at each edge: a word is accepted unless a whole frame is
   // already waiting behind the one on the line.
   always @(posedge clk) begin : model
      automatic bit a0;
      automatic bit a1;
      if (!resetN) begin
         q0.delete();
         q1.delete();
         err0_m <= 1'b0;
         err1_m <= 1'b0;
         mvalid <= 1'b1;
      end else begin
         a0 = send0 && (q0.size() <= F0);
         a1 = send1 && (q1.size() <= F1);
         if (send0 && !a0) err0_m <= 1'b1;
         if (send1 && !a1) err1_m <= 1'b1;
         if (q0.size() != 0) void'(q0.pop_front());
         if (q1.size() != 0) void'(q1.pop_front());
         if (a0) push_frame(0, {24'd0, pin0});
         if (a1) push_frame(1, {27'd0, pin1});
      end
   end

   always @(negedge clk) begin : compare
      if (mvalid) begin
         check("sout0",  sout0,  (q0.size() != 0) ? q0[0][0] : 1'b1);
         check("done0",  done0,  (q0.size() != 0) ? q0[0][1] : 1'b0);
         check("busy0",  busy0,  q0.size() != 0);
         check("ready0", ready0, q0.size() <= F0);
         check("err0",   err0,   err0_m);
         check("sout1",  sout1,  (q1.size() != 0) ? q1[0][0] : 1'b1);
         check("done1",  done1,  (q1.size() != 0) ? q1[0][1] : 1'b0);
         check("busy1",  busy1,  q1.size() != 0);
         check("ready1", ready1, q1.size() <= F1);
         check("err1",   err1,   err1_m);
      end
   end

   task automatic capture(input int first, input int last);
      for (int k = first; k <= last; k++) begin
         @(negedge clk);
         s0_tr[k] = sout0; d0_tr[k] = done0; b0_tr[k] = busy0;
         r0_tr[k] = ready0; e0_tr[k] = err0;
         s1_tr[k] = sout1; d1_tr[k] = done1; b1_tr[k] = busy1;
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bit exp_a5[11]  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
      bit exp_cfg[9]  = '{0, 1, 0, 1, 1, 0, 0, 1, 1};
      int bad;

      resetN = 1'b0; send0 = 1'b0; send1 = 1'b0; pin0 = '0; pin1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_sout0", sout0, 1'b1);
      check("rst_busy0", busy0, 1'b0);
      check("rst_done0", done0, 1'b0);
      check("rst_err0",  err0,  1'b0);
      check("rst_ready0", ready0, 1'b1);
      check("rst_sout1", sout1, 1'b1);
      @(posedge clk); #1 resetN = 1'b1;

      // Idle line
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (sout0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) bad++;
      end
      check("idle_line", bad, 0);

      // Single frame, 0xA5
      @(posedge clk); #1 send0 = 1'b1; pin0 = 8'hA5;
      @(posedge clk); #1 send0 = 1'b0; pin0 = 8'h00;
      capture(1, 50);
      for (int b = 0; b < 11; b++) check($sformatf("a5_bit%0d", b), s0_tr[2 + 4 * b], exp_a5[b]);
      check("a5_start_c1", s0_tr[1], 1'b0);
      check("a5_start_c4", s0_tr[4], 1'b0);
      check("a5_done43", d0_tr[43], 1'b0);
      check("a5_done44", d0_tr[44], 1'b1);
      check("a5_done45", d0_tr[45], 1'b0);
      check("a5_busy44", b0_tr[44], 1'b1);
      check("a5_busy45", b0_tr[45], 1'b0);

      // Back-to-back 0x01 then 0xFF
      @(posedge clk); #1 send0 = 1'b1; pin0 = 8'h01;
      @(posedge clk); #1 pin0 = 8'hFF;
      @(posedge clk); #1 send0 = 1'b0; pin0 = 8'h00;
      capture(2, 95);
      check("b2b_ready2", r0_tr[2], 1'b0);
      check("b2b_par1",   s0_tr[38], 1'b1);
      check("b2b_done44", d0_tr[44], 1'b1);
      check("b2b_start45", s0_tr[45], 1'b0);
      check("b2b_par2",   s0_tr[82], 1'b0);
      check("b2b_done88", d0_tr[88], 1'b1);
      check("b2b_busy89", b0_tr[89], 1'b0);
      check("b2b_err",    e0_tr[89], 1'b0);

      // Overrun: third word rejected
      @(posedge clk); #1 send0 = 1'b1; pin0 = 8'h3C;
      @(posedge clk); #1 pin0 = 8'hC3;
      @(posedge clk); #1 pin0 = 8'h5A;
      @(posedge clk); #1 send0 = 1'b0; pin0 = 8'h00;
      capture(3, 110);
      check("ovr_err3",  e0_tr[3], 1'b1);
      check("ovr_err88", e0_tr[88], 1'b1);
      check("ovr_done88", d0_tr[88], 1'b1);
      check("ovr_busy89", b0_tr[89], 1'b0);
      bad = 0;
      for (int k = 89; k <= 110; k++) if (d0_tr[k] !== 1'b0 || s0_tr[k] !== 1'b1) bad++;
      check("ovr_no_third", bad, 0);

      // Reset mid-frame with a queued word (err is still set from above)
      @(posedge clk); #1 send0 = 1'b1; pin0 = 8'h96;
      @(posedge clk); #1 pin0 = 8'h69;
      @(posedge clk); #1 send0 = 1'b0; pin0 = 8'h00;
      repeat (18) @(posedge clk);
      #1 resetN = 1'b0;
      @(posedge clk); #1 resetN = 1'b1;
      @(negedge clk);
      check("mrst_sout",  sout0,  1'b1);
      check("mrst_busy",  busy0,  1'b0);
      check("mrst_ready", ready0, 1'b1);
      check("mrst_err",   err0,   1'b0);
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done0 !== 1'b0 || sout0 !== 1'b1) bad++;
      end
      check("mrst_quiet", bad, 0);

      // Alternate configuration, Pin = 5'b10110
      @(posedge clk); #1 send1 = 1'b1; pin1 = 5'b10110;
      @(posedge clk); #1 send1 = 1'b0; pin1 = 5'b00000;
      capture(1, 12);
      for (int b = 0; b < 9; b++) check($sformatf("cfg_bit%0d", b), s1_tr[1 + b], exp_cfg[b]);
      check("cfg_done8",  d1_tr[8], 1'b0);
      check("cfg_done9",  d1_tr[9], 1'b1);
      check("cfg_busy10", b1_tr[10], 1'b0);
      check("cfg_idle10", s1_tr[10], 1'b1);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
